regfile_serial_loader: RTL and testbench

- Upstream write stage for the 4x4 register file.
- Assembles MSB-first serial bits into DATA_W-bit words.
- Writes each word into consecutive register addresses through the file's write port (data_in, write_add, write_en), then reports completion.
- Optional read-back sweep drives the file's read port so the loaded contents appear on the file's dataOut.

---
 rtl/regfile_serial_loader.sv | 181 ++++++++++++++++++
 tb/tb_regfile_serial_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_serial_loader.sv
// ---------------------------------------------------------------------------
// regfile_serial_loader
//   Write stage in front of the 4x4 register file. It collects MSB-first
//   serial bits into DATA_W-bit words and writes each word into consecutive
//   register addresses, 0 .. NUM_REGS-1, through the file's write port. When
//   the last word is written it reports completion on done.
//
//   Optional build macro: REGFILE_LOADER_READBACK_EN
//     When defined, a READ sweep follows the final write. It drives read_en /
//     read_add over addresses 0 .. NUM_REGS-1 so the loaded contents appear
//     on the register file's dataOut. When undefined, read_en and read_add
//     are tied to 0.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a load sequence (honoured in IDLE / DONE only)
//   ser_in     serial data bit, MSB first
//   ser_valid  ser_in is sampled this cycle
//   data_in    word to the register file (valid while write_en)
//   write_add  register address for the write (valid while write_en)
//   write_en   one-cycle write strobe
//   read_add   read-back address (readback build only)
//   read_en    read-back enable (readback build only)
//   busy       high in SHIFT, WRITE and READ
//   done       sequence complete; held until next start or reset
//   overrun    sticky; a serial bit arrived while it could not be accepted
// ---------------------------------------------------------------------------
module regfile_serial_loader #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 2,
  parameter int NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ser_in,
  input  logic              ser_valid,
  output logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] write_add,
  output logic              write_en,
  output logic [ADDR_W-1:0] read_add,
  output logic              read_en,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0]   LAST_BIT  = BC_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

`ifdef REGFILE_LOADER_READBACK_EN
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_WRITE, S_DONE, S_READ} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_WRITE, S_DONE} state_t;
`endif

  state_t state, state_nxt;

  // Only the DATA_W-1 bits collected so far are kept. The word is completed
  // by the bit arriving in the same cycle, so no MSB is ever shifted out.
  logic [DATA_W-2:0] shreg;
  logic [BC_W-1:0]   bit_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [DATA_W-1:0] word_nxt;
  logic              last_bit;

  assign word_nxt = {shreg, ser_in};
  assign last_bit = ser_valid && (bit_cnt == LAST_BIT);

`ifdef REGFILE_LOADER_READBACK_EN
  logic [ADDR_W-1:0] rd_cnt;
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_SHIFT;
      S_SHIFT:        if (last_bit) state_nxt = S_WRITE;
      S_WRITE: begin
        if (addr_cnt == LAST_ADDR) begin
`ifdef REGFILE_LOADER_READBACK_EN
          state_nxt = S_READ;
`else
          state_nxt = S_DONE;
`endif
        end else begin
          state_nxt = S_SHIFT;
        end
      end
`ifdef REGFILE_LOADER_READBACK_EN
      S_READ:         if (rd_cnt == LAST_ADDR) state_nxt = S_DONE;
`endif
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Strobes and status follow the state directly. done can be decoded from
  // the state because DONE is left only by start or reset.
  assign write_en = (state == S_WRITE);
  assign done     = (state == S_DONE);
`ifdef REGFILE_LOADER_READBACK_EN
  assign busy     = (state == S_SHIFT) || (state == S_WRITE) || (state == S_READ);
  assign read_en  = (state == S_READ);
  assign read_add = rd_cnt;
`else
  assign busy     = (state == S_SHIFT) || (state == S_WRITE);
  assign read_en  = 1'b0;
  assign read_add = '0;
`endif

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      addr_cnt  <= '0;
      data_in   <= '0;
      write_add <= '0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // ser_valid is deliberately ignored here; it does not set overrun.
          if (start) begin
            bit_cnt  <= '0;
            addr_cnt <= '0;
            overrun  <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (ser_valid) begin
            shreg   <= word_nxt[DATA_W-2:0];
            bit_cnt <= bit_cnt + BC_W'(1);
          end
          // Capture the word and its address on the last bit so both are
          // stable for the whole WRITE cycle and hold afterwards.
          if (last_bit) begin
            data_in   <= word_nxt;
            write_add <= addr_cnt;
          end
        end
        S_WRITE: begin
          if (ser_valid) overrun <= 1'b1;
          if (addr_cnt != LAST_ADDR) begin
            addr_cnt <= addr_cnt + ADDR_W'(1);
            bit_cnt  <= '0;
          end
        end
`ifdef REGFILE_LOADER_READBACK_EN
        S_READ: begin
          if (ser_valid) overrun <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef REGFILE_LOADER_READBACK_EN
  // Read address: cleared as READ is entered, stepped each READ cycle, and
  // left at NUM_REGS-1 when the sweep ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= '0;
    end else if (state == S_WRITE && addr_cnt == LAST_ADDR) begin
      rd_cnt <= '0;
    end else if (state == S_READ && rd_cnt != LAST_ADDR) begin
      rd_cnt <= rd_cnt + ADDR_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_regfile_serial_loader.sv
// ---------------------------------------------------------------------------
// tb_regfile_serial_loader
//   Directed self-checking bench for regfile_serial_loader (DATA_W=4,
//   ADDR_W=2, NUM_REGS=4).
//   Covers: reset, full load with read-back when REGFILE_LOADER_READBACK_EN
//   is defined, stall, overrun, and reset in the middle of a word.
//   Inputs change 1 time unit after the rising edge, and outputs are
//   checked at that same point.
// ---------------------------------------------------------------------------
module tb_regfile_serial_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       ser_in;
  logic       ser_valid;
  logic [3:0] data_in;
  logic [1:0] write_add;
  logic       write_en;
  logic [1:0] read_add;
  logic       read_en;
  logic       busy;
  logic       done;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_serial_loader #(.DATA_W(4), .ADDR_W(2), .NUM_REGS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ser_in(ser_in),
    .ser_valid(ser_valid), .data_in(data_in), .write_add(write_add),
    .write_en(write_en), .read_add(read_add), .read_en(read_en),
    .busy(busy), .done(done), .overrun(overrun)
  );

`ifdef REGFILE_LOADER_READBACK_EN
  // Register file model attached to the loader's write and read ports.
  logic [3:0] rf [4];
  logic [3:0] data_out;
  always @(posedge clk) if (write_en) rf[write_add] <= data_in;
  assign data_out = rf[read_add];
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ser_valid = 1'b1;
    ser_in    = b;
    tick();
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; ser_valid = 1'b0; ser_in = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Step until done rises, with a bounded cycle budget.
  task automatic wait_done(input string tag);
    for (int i = 0; i < 12 && !done; i++) tick();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done_timeout got %b want 1", tag, done);
    end
  endtask

  // ------------------------------------------------------------------
  task automatic test_reset();
    logic [14:0] outs;
    rst_n = 1'b0; start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      ser_in    = 1'($urandom_range(0, 1));
      ser_valid = 1'($urandom_range(0, 1));
      tick();
      outs = {data_in, write_add, write_en, read_add, read_en, busy, done, overrun};
      n_checks++;
      if (outs !== 15'h0) begin
        n_fail++;
        $display("FAIL reset_outs%0d got %h want 0", c, outs);
      end
    end
    rst_n = 1'b1;
    // ser_valid in IDLE is ignored: no overrun and no activity.
    ser_valid = 1'b1; ser_in = 1'b1;
    tick(); tick();
    n_checks++;
    if ({busy, overrun, write_en, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_ignore got %b want 0000", {busy, overrun, write_en, done});
    end
    ser_valid = 1'b0;
  endtask

  task automatic test_full_load();
    logic [3:0] exp_w [4];
    exp_w[0] = 4'b0001; exp_w[1] = 4'b0010; exp_w[2] = 4'b0011; exp_w[3] = 4'b0100;
    do_reset();
    do_start();
    n_checks++;
    if ({busy, done} !== 2'b10) begin
      n_fail++;
      $display("FAIL full_start got busy/done %b want 10", {busy, done});
    end
    for (int w = 0; w < 4; w++) begin
      for (int i = 3; i >= 1; i--) send_bit(exp_w[w][i]);
      n_checks++;
      if (write_en !== 1'b0) begin
        n_fail++;
        $display("FAIL full_early_we%0d got %b want 0", w, write_en);
      end
      send_bit(exp_w[w][0]);
      n_checks++;
      if ({write_en, write_add, data_in} !== {1'b1, 2'(w), exp_w[w]}) begin
        n_fail++;
        $display("FAIL full_write%0d got we/add/data %b/%b/%b want 1/%b/%b",
                 w, write_en, write_add, data_in, 2'(w), exp_w[w]);
      end
      ser_valid = 1'b0;
      tick();
      n_checks++;
      if (write_en !== 1'b0) begin
        n_fail++;
        $display("FAIL full_pulse_end%0d got %b want 0", w, write_en);
      end
    end
`ifdef REGFILE_LOADER_READBACK_EN
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if ({read_en, read_add, data_out, done} !== {1'b1, 2'(j), exp_w[j], 1'b0}) begin
        n_fail++;
        $display("FAIL readback%0d got en/add/dout/done %b/%b/%b/%b want 1/%b/%b/0",
                 j, read_en, read_add, data_out, done, 2'(j), exp_w[j]);
      end
      tick();
    end
    n_checks++;
    if ({read_en, read_add} !== 3'b011) begin
      n_fail++;
      $display("FAIL readback_end got en/add %b/%b want 0/11", read_en, read_add);
    end
`endif
    n_checks++;
    if ({done, busy, write_add, data_in} !== {1'b1, 1'b0, 2'b11, 4'b0100}) begin
      n_fail++;
      $display("FAIL full_done got done/busy/add/data %b/%b/%b/%b want 1/0/11/0100",
               done, busy, write_add, data_in);
    end
    // ser_valid in DONE is ignored.
    ser_valid = 1'b1; ser_in = 1'b1;
    tick(); tick();
    ser_valid = 1'b0;
    n_checks++;
    if ({done, overrun, write_en} !== 3'b100) begin
      n_fail++;
      $display("FAIL done_ignore got done/ovr/we %b want 100", {done, overrun, write_en});
    end
  endtask

  task automatic test_stall();
    do_reset();
    do_start();
    send_bit(1'b1);
    send_bit(1'b1);
    ser_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (write_en !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_we%0d got %b want 0", c, write_en);
      end
    end
    send_bit(1'b1);
    n_checks++;
    if (write_en !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_3rd_we got %b want 0", write_en);
    end
    send_bit(1'b0);
    n_checks++;
    if ({write_en, write_add, data_in} !== 7'b1_00_1110) begin
      n_fail++;
      $display("FAIL stall_write got we/add/data %b/%b/%b want 1/00/1110",
               write_en, write_add, data_in);
    end
    ser_valid = 1'b0;
    tick();
    n_checks++;
    if ({write_en, overrun} !== 2'b00) begin
      n_fail++;
      $display("FAIL stall_after got we/ovr %b want 00", {write_en, overrun});
    end
  endtask

  task automatic test_overrun();
    do_reset();
    do_start();
    send_word(4'b1010);
    n_checks++;
    if ({write_en, data_in, overrun} !== 6'b1_1010_0) begin
      n_fail++;
      $display("FAIL ovr_first got we/data/ovr %b/%b/%b want 1/1010/0",
               write_en, data_in, overrun);
    end
    send_bit(1'b1);            // lands in the WRITE cycle and is dropped
    n_checks++;
    if ({overrun, write_en} !== 2'b10) begin
      n_fail++;
      $display("FAIL ovr_set got ovr/we %b want 10", {overrun, write_en});
    end
    send_word(4'b0101);
    n_checks++;
    if ({write_en, write_add, data_in, overrun} !== 8'b1_01_0101_1) begin
      n_fail++;
      $display("FAIL ovr_second got we/add/data/ovr %b/%b/%b/%b want 1/01/0101/1",
               write_en, write_add, data_in, overrun);
    end
    ser_valid = 1'b0; tick();
    send_word(4'b0011);
    ser_valid = 1'b0; tick();
    send_word(4'b1100);
    ser_valid = 1'b0; tick();
    wait_done("ovr");
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_sticky got %b want 1", overrun);
    end
    do_start();
    n_checks++;
    if ({overrun, done, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL ovr_clear got ovr/done/busy %b want 001", {overrun, done, busy});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_start();
    send_word(4'b0001);
    ser_valid = 1'b0; tick();
    send_bit(1'b1);
    send_bit(1'b0);
    ser_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({data_in, write_add, write_en, busy, done, overrun} !== 10'h0) begin
      n_fail++;
      $display("FAIL rstmid_outs got data/add/we/busy/done/ovr %b/%b/%b/%b/%b/%b want all 0",
               data_in, write_add, write_en, busy, done, overrun);
    end
    tick();
    rst_n = 1'b1;
    tick();
    do_start();
    send_word(4'b0110);
    n_checks++;
    if ({write_en, write_add, data_in} !== 7'b1_00_0110) begin
      n_fail++;
      $display("FAIL rstmid_reload got we/add/data %b/%b/%b want 1/00/0110",
               write_en, write_add, data_in);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ser_in = 1'b0; ser_valid = 1'b0;
    test_reset();
    test_full_load();
    test_stall();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
